// File: rtl/sdram_capture_writer.sv
// Streams sample words into an SDRAM ring or one-shot buffer using fixed-length
// Avalon-MM write bursts toward f2h_sdram0.
module sdram_capture_writer #(
    parameter int unsigned ADDR_W    = 27,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  circular,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     len_words,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_W-1:0]     avm_address,
    output logic [7:0]            avm_burstcount,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic                  done,
    output logic                  wrapped,
    output logic [ADDR_W-1:0]     wr_ptr
);

    localparam int unsigned       BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic                circ_q, circ_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   burst_addr_q, burst_addr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                stop_q, stop_d;
    logic                wrapped_q, wrapped_d;

    logic                accept;
    logic [ADDR_W-1:0]   next_addr;
    logic                at_end;

    // State and run-context registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            end_q        <= '0;
            circ_q       <= 1'b0;
            wr_ptr_q     <= '0;
            burst_addr_q <= '0;
            beat_q       <= '0;
            stop_q       <= 1'b0;
            wrapped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            end_q        <= end_d;
            circ_q       <= circ_d;
            wr_ptr_q     <= wr_ptr_d;
            burst_addr_q <= burst_addr_d;
            beat_q       <= beat_d;
            stop_q       <= stop_d;
            wrapped_q    <= wrapped_d;
        end
    end

    // Next-state logic: bursts always run to BURST_LEN beats; stop and buffer end
    // are only acted on at a burst boundary.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        end_d        = end_q;
        circ_d       = circ_q;
        wr_ptr_d     = wr_ptr_q;
        burst_addr_d = burst_addr_q;
        beat_d       = beat_q;
        stop_d       = stop_q;
        wrapped_d    = wrapped_q;

        accept    = (state_q == BURST) && in_valid && !avm_waitrequest;
        next_addr = wr_ptr_q + ADDR_W'(1);
        at_end    = (next_addr == end_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = BURST;
                    base_d       = base_addr;
                    end_d        = base_addr + len_words;
                    circ_d       = circular;
                    wr_ptr_d     = base_addr;
                    burst_addr_d = base_addr;
                    beat_d       = '0;
                    stop_d       = 1'b0;
                    wrapped_d    = 1'b0;
                end
            end
            BURST: begin
                stop_d = stop_q | stop;
                if (accept) begin
                    wr_ptr_d = next_addr;
                    if (beat_q == LAST_BEAT) begin
                        beat_d       = '0;
                        burst_addr_d = next_addr;
                        // Wrap is applied even when stopping so wr_ptr always names
                        // the next word that would be written.
                        if (at_end && circ_q) begin
                            wr_ptr_d     = base_q;
                            burst_addr_d = base_q;
                            wrapped_d    = 1'b1;
                        end
                        if (stop_q || stop || (at_end && !circ_q)) begin
                            state_d = DONE;
                            stop_d  = 1'b0;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy           = (state_q == BURST);
    assign done           = (state_q == DONE);
    assign wrapped        = wrapped_q;
    assign wr_ptr         = wr_ptr_q;
    assign in_ready       = (state_q == BURST) && !avm_waitrequest;
    assign avm_write      = (state_q == BURST) && in_valid;
    assign avm_address    = burst_addr_q;
    assign avm_burstcount = (state_q == BURST) ? 8'(BURST_LEN) : 8'd0;
    assign avm_writedata  = in_data;
    assign avm_byteenable = '1;

endmodule

// File: doc/sdram_capture_writer.md
SDRAM_CAPTURE_WRITER -- requirements
Module: sdram_capture_writer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 27, meaning SDRAM word-address width in 256-bit words.
REQ-002 The block SHALL have parameter DATA_W, default 256, meaning sample-word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 16, meaning beats per burst, a power of two from 1 to 128.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk, input, 1, single clock domain for all logic.
REQ-005 reset_n, input, 1, asynchronous active-low reset.
REQ-006 start, input, 1, one-cycle pulse that begins a capture run; ignored while busy=1.
REQ-007 stop, input, 1, one-cycle pulse that requests termination.
REQ-008 circular, input, 1, sampled at start; 1 = wrap buffer, 0 = one-shot.
REQ-009 base_addr, input, ADDR_W, buffer start word address, sampled at start, multiple of BURST_LEN.
REQ-010 len_words, input, ADDR_W, buffer length in words, sampled at start, nonzero multiple of BURST_LEN.
REQ-011 in_data / in_valid / in_ready, input / input / output, DATA_W / 1 / 1, sample stream; a beat transfers when in_valid and in_ready are both 1.
REQ-012 avm_address / avm_burstcount / avm_write / avm_writedata / avm_byteenable, outputs, ADDR_W / 8 / 1 / DATA_W / DATA_W/8, Avalon-MM burst write master toward f2h_sdram0.
REQ-013 avm_waitrequest, input, 1, slave stall.
REQ-014 busy / done / wrapped / wr_ptr, outputs, 1 / 1 / 1 / ADDR_W, status: run active / one-cycle completion pulse / buffer wrapped at least once / next word address to be written.

Function
REQ-015 The state machine SHALL have states IDLE, BURST and DONE.
REQ-016 IDLE->BURST SHALL occur on start: latch base_addr, len_words and circular; set wr_ptr=base_addr and wrapped=0; busy=1 from the next cycle.
REQ-017 In BURST, avm_address SHALL equal the burst start address, avm_burstcount SHALL equal BURST_LEN, and both SHALL hold constant for the entire burst.
REQ-018 avm_write SHALL equal in_valid while in BURST, and 0 otherwise; gaps between beats are permitted.
REQ-019 avm_writedata SHALL equal in_data, and avm_byteenable SHALL be all ones.
REQ-020 in_ready SHALL equal (state==BURST) and not avm_waitrequest; a beat is accepted only when avm_write=1 and avm_waitrequest=0, and that is the in_valid&in_ready transfer.
REQ-021 A beat counter SHALL count accepted beats 0..BURST_LEN-1; wr_ptr SHALL increment by 1 per accepted beat.
REQ-022 On the last beat of a burst, if the next address equals base+len, then:
  - in circular mode, wr_ptr SHALL become base, wrapped SHALL become 1, and the block SHALL stay in BURST;
  - in one-shot mode, the block SHALL go to DONE.
REQ-023 Otherwise, the block SHALL start the next burst at the next address.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_W; base+len overflowing SHALL wrap silently.
REQ-025 A stop pulse SHALL be latched; the current burst SHALL always complete all BURST_LEN beats, because Avalon forbids truncation.
REQ-026 After a burst completes, a latched stop SHALL move the block to DONE.
REQ-027 A stop pulse in IDLE SHALL be ignored.
REQ-028 If stop and the last beat of the buffer occur in the same cycle, the block SHALL go to DONE exactly once.
REQ-029 If stop arrives before any beat of a burst has been accepted, the block SHALL still write the full burst.
REQ-030 DONE SHALL last one cycle, with done=1 and busy=0 in that cycle, then go to IDLE; wr_ptr and wrapped SHALL hold their values until the next start.
REQ-031 A start pulse arriving in BURST or DONE SHALL be ignored.

Reset
REQ-032 While reset_n=0, asynchronously: state=IDLE; avm_write=0, avm_address=0, avm_burstcount=0; in_ready=0; busy=0, done=0, wrapped=0, wr_ptr=0; beat counter and latched stop cleared.
REQ-033 Reset asserted mid-burst SHALL abandon the burst immediately; the system is expected to reset the slave path together with this block.
REQ-034 Reset release SHALL be synchronised externally; the block SHALL take no action until a start pulse arrives after release.

Verification
REQ-035 One-shot fill: BURST_LEN=16, base=0x100, len=32, in_valid=1, waitrequest=0 -> two bursts at 0x100 and 0x110, burstcount=16 each, 32 writes, done pulse at cycle 33 after start, wr_ptr=0x120.
REQ-036 Circular wrap: base=0x200, len=16, circular=1, 40 beats streamed -> address sequence 0x200,0x200,0x200; wrapped=1 after beat 16; wr_ptr=0x208 after beat 40; busy stays 1.
REQ-037 Backpressure: waitrequest toggled randomly 50% -> every in_data word appears on avm_writedata exactly once in order; address and burstcount stable during stalls; in_ready=0 whenever waitrequest=1.
REQ-038 Stop mid-burst: stop after beat 5 of a 16-beat burst -> 11 more beats accepted, then done=1, busy=0, no new burst address issued.
REQ-039 Input starvation: in_valid low for 10 cycles mid-burst -> avm_write=0 during the gap, burst resumes with no extra address phase.
REQ-040 Async reset mid-burst: reset_n pulled low at beat 7 -> avm_write=0 and busy=0 within the same cycle; a subsequent start at base=0x300 writes from 0x300.
